// File: rtl/npu_pkg.sv
// Shared NPU definitions: array geometry, UB address width and the drain sequencer states.
package npu_pkg;

   localparam int ARRAY_SIZE    = 4;
   localparam int UB_ADDR_WIDTH = 16;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      WRITE   = 2'd2,
      DONE    = 2'd3
   } drain_state_t;

endpackage

// File: rtl/ppu_drain_ctrl_if.sv
// Unified Buffer write port: request/address from the drain sequencer, ready back from the UB.
interface ppu_drain_ctrl_if #(
   parameter int ADDR_WIDTH = 16
);

   logic                  ub_we;
   logic [ADDR_WIDTH-1:0] ub_addr;
   logic                  ub_ready;

   modport master (output ub_we, output ub_addr, input ub_ready);
   modport slave  (input ub_we, input ub_addr, output ub_ready);

endinterface

// File: rtl/ppu_drain_ctrl_stride_addr_gen.sv
// Registered base + k*stride address accumulator; wraps modulo 2^ADDR_WIDTH.
module stride_addr_gen #(
   parameter int ADDR_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load,
   input  logic                  advance,
   input  logic [ADDR_WIDTH-1:0] load_val,
   input  logic [ADDR_WIDTH-1:0] stride,
   output logic [ADDR_WIDTH-1:0] addr
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr <= '0;
      end else if (load) begin
         addr <= load_val;
      end else if (advance) begin
         addr <= addr + stride;
      end
   end

endmodule

// File: rtl/ppu_drain_ctrl.sv
// Drains one accumulated tile: N row captures into the PPU transpose buffer, then N column writes to the UB.
module ppu_drain_ctrl
   import npu_pkg::*;
#(
   parameter int N          = ARRAY_SIZE,
   parameter int ADDR_WIDTH = UB_ADDR_WIDTH,
   parameter int IDX_W      = $clog2(N)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [ADDR_WIDTH-1:0] stride,
   input  logic                  acc_valid,
   output logic                  capture_en,
   output logic [IDX_W-1:0]      cycle_idx,
   ppu_drain_ctrl_if.master      ub,
   output logic                  busy,
   output logic                  done
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

   drain_state_t          state;
   logic [ADDR_WIDTH-1:0] base_q;
   logic [ADDR_WIDTH-1:0] stride_q;
   logic [ADDR_WIDTH-1:0] acc_addr;
   logic                  last_idx;
   logic                  addr_load;
   logic                  addr_advance;

   assign last_idx     = (cycle_idx == LAST_IDX);
   assign addr_load    = (state == CAPTURE) && acc_valid && last_idx;
   assign addr_advance = (state == WRITE) && ub.ub_ready;

   // cycle_idx counts captured rows, then is reused as the PPU column select while writing.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cycle_idx <= '0;
         base_q    <= '0;
         stride_q  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  base_q    <= base_addr;
                  stride_q  <= stride;
                  cycle_idx <= '0;
                  state     <= CAPTURE;
               end
            end
            CAPTURE: begin
               if (acc_valid) begin
                  if (last_idx) begin
                     cycle_idx <= '0;
                     state     <= WRITE;
                  end else begin
                     cycle_idx <= cycle_idx + IDX_W'(1);
                  end
               end
            end
            WRITE: begin
               if (ub.ub_ready) begin
                  if (last_idx) begin
                     cycle_idx <= '0;
                     state     <= DONE;
                  end else begin
                     cycle_idx <= cycle_idx + IDX_W'(1);
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   stride_addr_gen #(
      .ADDR_WIDTH(ADDR_WIDTH)
   ) u_addr_gen (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (addr_load),
      .advance  (addr_advance),
      .load_val (base_q),
      .stride   (stride_q),
      .addr     (acc_addr)
   );

   // The accumulator keeps its last value after the tile, so the bus is masked outside WRITE.
   assign capture_en  = (state == CAPTURE) && acc_valid;
   assign ub.ub_we    = (state == WRITE);
   assign ub.ub_addr  = (state == WRITE) ? acc_addr : '0;
   assign busy        = (state != IDLE);
   assign done        = (state == DONE);

endmodule

// File: tb/tb_ppu_drain_ctrl.sv
// Directed bench for ppu_drain_ctrl (N=4): drain timing, stalls, backpressure, wrap, start-while-busy, async reset.
module tb_ppu_drain_ctrl;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [15:0] base_addr;
   logic [15:0] stride;
   logic        acc_valid;
   logic        capture_en;
   logic [1:0]  cycle_idx;
   logic        busy;
   logic        done;

   int vectors;
   int miscompares;
   int pulses;
   int accepted;
   int done_cnt;

   logic pat [7]     = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
   int   pat_idx [7] = '{0, 1, 1, 1, 2, 3, 3};
   logic rdy_seq [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
   int   rdy_idx [7] = '{0, 1, 2, 2, 2, 2, 3};

   ppu_drain_ctrl_if #(.ADDR_WIDTH(16)) ub_bus ();

   ppu_drain_ctrl #(
      .N          (4),
      .ADDR_WIDTH (16)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .base_addr  (base_addr),
      .stride     (stride),
      .acc_valid  (acc_valid),
      .capture_en (capture_en),
      .cycle_idx  (cycle_idx),
      .ub         (ub_bus),
      .busy       (busy),
      .done       (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Inputs change on the falling edge; outputs are sampled 1 unit later, well before the next rising edge.
   task automatic apply_stimulus(input logic s, input logic av, input logic rdy);
      @(negedge clk);
      start           = s;
      acc_valid       = av;
      ub_bus.ub_ready = rdy;
      #1;
   endtask

   task automatic drain_full(input logic [15:0] b, input logic [15:0] s, input logic [63:0] exp_addrs);
      base_addr = b;
      stride    = s;
      apply_stimulus(1'b1, 1'b1, 1'b1);
      check_output("idle_busy", 32'(busy), 32'd0);
      check_output("idle_cap", 32'(capture_en), 32'd0);
      for (int k = 0; k < 4; k++) begin
         apply_stimulus(1'b0, 1'b1, 1'b1);
         check_output("cap_en", 32'(capture_en), 32'd1);
         check_output("cap_idx", 32'(cycle_idx), 32'(k));
         check_output("cap_we", 32'(ub_bus.ub_we), 32'd0);
      end
      for (int k = 0; k < 4; k++) begin
         apply_stimulus(1'b0, 1'b1, 1'b1);
         check_output("wr_we", 32'(ub_bus.ub_we), 32'd1);
         check_output("wr_addr", 32'(ub_bus.ub_addr), 32'(exp_addrs[k*16 +: 16]));
         check_output("wr_idx", 32'(cycle_idx), 32'(k));
         check_output("wr_cap", 32'(capture_en), 32'd0);
         check_output("wr_done", 32'(done), 32'd0);
      end
      apply_stimulus(1'b0, 1'b1, 1'b1);
      check_output("done_pulse", 32'(done), 32'd1);
      check_output("done_busy", 32'(busy), 32'd1);
      check_output("done_we", 32'(ub_bus.ub_we), 32'd0);
      check_output("done_cap", 32'(capture_en), 32'd0);
      apply_stimulus(1'b0, 1'b1, 1'b1);
      check_output("post_done", 32'(done), 32'd0);
      check_output("post_busy", 32'(busy), 32'd0);
   endtask

   initial begin
      vectors         = 0;
      miscompares     = 0;
      rst_n           = 1'b0;
      start           = 1'b0;
      base_addr       = '0;
      stride          = '0;
      acc_valid       = 1'b0;
      ub_bus.ub_ready = 1'b0;

      #2;
      check_output("rst_busy", 32'(busy), 32'd0);
      check_output("rst_done", 32'(done), 32'd0);
      check_output("rst_cap", 32'(capture_en), 32'd0);
      check_output("rst_we", 32'(ub_bus.ub_we), 32'd0);
      check_output("rst_addr", 32'(ub_bus.ub_addr), 32'd0);
      check_output("rst_idx", 32'(cycle_idx), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      $display("[TB] basic drain");
      drain_full(16'h0100, 16'd4, 64'h010C_0108_0104_0100);

      $display("[TB] capture stall");
      base_addr = 16'h0040;
      stride    = 16'h0001;
      pulses    = 0;
      apply_stimulus(1'b1, 1'b0, 1'b1);
      check_output("stall_idle_cap", 32'(capture_en), 32'd0);
      for (int i = 0; i < 7; i++) begin
         apply_stimulus(1'b0, pat[i], 1'b1);
         check_output("stall_cap", 32'(capture_en), 32'(pat[i]));
         check_output("stall_idx", 32'(cycle_idx), 32'(pat_idx[i]));
         check_output("stall_we", 32'(ub_bus.ub_we), 32'd0);
         if (capture_en) pulses++;
      end
      check_output("stall_pulses", 32'(pulses), 32'd4);
      for (int k = 0; k < 4; k++) begin
         apply_stimulus(1'b0, 1'b0, 1'b1);
         check_output("stall_wr_we", 32'(ub_bus.ub_we), 32'd1);
         check_output("stall_wr_idx", 32'(cycle_idx), 32'(k));
         check_output("stall_wr_addr", 32'(ub_bus.ub_addr), 32'h0040 + 32'(k));
      end
      apply_stimulus(1'b0, 1'b0, 1'b1);
      check_output("stall_done", 32'(done), 32'd1);
      apply_stimulus(1'b0, 1'b0, 1'b1);
      check_output("stall_idle", 32'(busy), 32'd0);

      $display("[TB] UB backpressure");
      base_addr = 16'h0200;
      stride    = 16'h0010;
      accepted  = 0;
      done_cnt  = 0;
      apply_stimulus(1'b1, 1'b1, 1'b1);
      for (int k = 0; k < 4; k++) begin
         apply_stimulus(1'b0, 1'b1, 1'b1);
         check_output("bp_cap_idx", 32'(cycle_idx), 32'(k));
      end
      for (int i = 0; i < 7; i++) begin
         apply_stimulus(1'b0, 1'b1, rdy_seq[i]);
         check_output("bp_we", 32'(ub_bus.ub_we), 32'd1);
         check_output("bp_idx", 32'(cycle_idx), 32'(rdy_idx[i]));
         check_output("bp_addr", 32'(ub_bus.ub_addr), 32'h0200 + 32'(rdy_idx[i]) * 32'h10);
         if (ub_bus.ub_we && ub_bus.ub_ready) accepted++;
         if (done) done_cnt++;
      end
      for (int i = 0; i < 3; i++) begin
         apply_stimulus(1'b0, 1'b1, 1'b1);
         if (done) done_cnt++;
      end
      check_output("bp_accepted", 32'(accepted), 32'd4);
      check_output("bp_done_cnt", 32'(done_cnt), 32'd1);
      check_output("bp_idle", 32'(busy), 32'd0);

      $display("[TB] address wrap and zero stride");
      drain_full(16'hFFFC, 16'd4, 64'h0008_0004_0000_FFFC);
      drain_full(16'h1234, 16'd0, 64'h1234_1234_1234_1234);

      $display("[TB] start while busy");
      base_addr = 16'h0300;
      stride    = 16'h0008;
      done_cnt  = 0;
      apply_stimulus(1'b1, 1'b1, 1'b1);
      apply_stimulus(1'b0, 1'b1, 1'b1);
      base_addr = 16'h0999;
      stride    = 16'h0077;
      apply_stimulus(1'b1, 1'b1, 1'b1);
      check_output("sb_cap_idx", 32'(cycle_idx), 32'd1);
      apply_stimulus(1'b0, 1'b1, 1'b1);
      apply_stimulus(1'b0, 1'b1, 1'b1);
      check_output("sb_cap_last", 32'(cycle_idx), 32'd3);
      for (int k = 0; k < 4; k++) begin
         if (k == 1) base_addr = 16'h0AAA;
         apply_stimulus((k == 1), 1'b1, 1'b1);
         check_output("sb_addr", 32'(ub_bus.ub_addr), 32'h0300 + 32'(k) * 32'd8);
         check_output("sb_idx", 32'(cycle_idx), 32'(k));
      end
      apply_stimulus(1'b0, 1'b1, 1'b1);
      if (done) done_cnt++;
      base_addr = 16'h0400;
      stride    = 16'h0002;
      apply_stimulus(1'b1, 1'b1, 1'b1);
      if (done) done_cnt++;
      check_output("sb_done_cnt", 32'(done_cnt), 32'd1);
      check_output("sb_idle_busy", 32'(busy), 32'd0);
      for (int k = 0; k < 4; k++) begin
         apply_stimulus(1'b0, 1'b1, 1'b1);
         check_output("sb2_cap", 32'(capture_en), 32'd1);
         check_output("sb2_idx", 32'(cycle_idx), 32'(k));
      end
      for (int k = 0; k < 4; k++) begin
         apply_stimulus(1'b0, 1'b1, 1'b1);
         check_output("sb2_addr", 32'(ub_bus.ub_addr), 32'h0400 + 32'(k) * 32'd2);
      end
      apply_stimulus(1'b0, 1'b1, 1'b1);
      check_output("sb2_done", 32'(done), 32'd1);
      apply_stimulus(1'b0, 1'b1, 1'b1);

      $display("[TB] reset mid-write");
      base_addr = 16'h0500;
      stride    = 16'h0004;
      apply_stimulus(1'b1, 1'b1, 1'b1);
      for (int k = 0; k < 5; k++) apply_stimulus(1'b0, 1'b1, 1'b1);
      apply_stimulus(1'b0, 1'b1, 1'b1);
      check_output("mr_idx", 32'(cycle_idx), 32'd1);
      check_output("mr_addr", 32'(ub_bus.ub_addr), 32'h0504);
      #2;
      rst_n = 1'b0;
      #1;
      check_output("mr_we", 32'(ub_bus.ub_we), 32'd0);
      check_output("mr_addr0", 32'(ub_bus.ub_addr), 32'd0);
      check_output("mr_idx0", 32'(cycle_idx), 32'd0);
      check_output("mr_busy", 32'(busy), 32'd0);
      check_output("mr_done", 32'(done), 32'd0);
      check_output("mr_cap", 32'(capture_en), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      drain_full(16'h0600, 16'd3, 64'h0609_0606_0603_0600);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
